dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder_pkg.sv | 14 +
 rtl/dmem_array.sv | 23 ++
 rtl/dmem_responder.sv | 111 +++++++++++
 3 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared types and defaults for the data-memory responder.
package dmem_responder_pkg;

  localparam int WORD_W          = 32;
  localparam int DEF_DEPTH_WORDS = 128;
  localparam int DEF_WAIT_CYCLES = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_array.sv
// Word storage: single port, synchronous write, combinational read, no reset.
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int AW          = 7
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_idx,
  input  logic [WORD_W-1:0] i_wdata,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH_WORDS];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_idx] <= i_wdata;
  end

  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/dmem_responder.sv
// Request/response memory responder: accepts one access, waits WAIT_CYCLES,
// performs the access on the edge entering RESP and holds the response until taken.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int         AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);
  localparam logic       NO_WAIT = (WAIT_CYCLES == 0);

  // Full-width compare so any set bit above the index field is out of range.
  function automatic logic addr_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= 32'(DEPTH_WORDS));
  endfunction

  state_t        r_state, w_next;
  logic [3:0]    r_cnt;
  logic          r_write;
  logic [31:0]   r_addr, r_wdata, r_rdata;
  logic          r_err;

  logic          w_accept, w_enter_resp;
  logic          w_acc_write, w_acc_err, w_mem_we;
  logic [31:0]   w_acc_addr, w_acc_wdata, w_mem_rdata;
  logic [AW-1:0] w_idx;

  assign w_accept     = req_valid_i && (r_state == IDLE);
  assign w_enter_resp = (w_accept && NO_WAIT) || ((r_state == WAIT) && (r_cnt == 4'd1));

  // With no wait states the access happens on the accepting edge, before capture.
  assign w_acc_write = (r_state == IDLE) ? req_write_i : r_write;
  assign w_acc_addr  = (r_state == IDLE) ? req_addr_i  : r_addr;
  assign w_acc_wdata = (r_state == IDLE) ? req_wdata_i : r_wdata;
  assign w_acc_err   = addr_err(w_acc_addr);
  assign w_idx       = w_acc_addr[AW+1:2];
  assign w_mem_we    = w_enter_resp && w_acc_write && !w_acc_err && rst_i;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .i_clk  (clk_i),
    .i_we   (w_mem_we),
    .i_idx  (w_idx),
    .i_wdata(w_acc_wdata),
    .o_rdata(w_mem_rdata)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = NO_WAIT ? RESP : WAIT;
      WAIT:    if (r_cnt == 4'd1) w_next = RESP;
      RESP:    if (rsp_ready_i) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = (r_state == IDLE);
    rsp_valid_o = (r_state == RESP);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cnt   <= 4'd0;
      r_write <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt   <= WAIT_LD;
        r_write <= req_write_i;
        r_addr  <= req_addr_i;
        r_wdata <= req_wdata_i;
      end else if ((r_state == WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_enter_resp) begin
        r_rdata <= (!w_acc_err && !w_acc_write) ? w_mem_rdata : 32'd0;
        r_err   <= w_acc_err;
      end
    end
  end

  assign rsp_rdata_o = r_rdata;
  assign rsp_err_o   = r_err;

endmodule
